// File: rtl/xunit_msched_if.sv
// rtl/xunit_msched_if.sv - bus bundle between a driver and the SHA-256 message scheduler
// Signals:
//   run     driver -> sched  one-cycle start pulse
//   delay0  driver -> sched  start delay in cycles, sampled with run
//   in0..15 driver -> sched  message block words M[0..15], sampled in LOAD only
//   done    sched -> driver  high while idle
//   valid   sched -> driver  high during the 64 stream cycles
//   out0    sched -> driver  schedule word W[t]
//   out1    sched -> driver  round constant K[t]
interface xunit_msched_if #(
  parameter int DATA_W = 32
);
  logic              run;
  logic [7:0]        delay0;
  logic [DATA_W-1:0] in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7;
  logic [DATA_W-1:0] in8,  in9,  in10, in11, in12, in13, in14, in15;
  logic              done;
  logic              valid;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;

  modport master (
    output run, delay0,
    output in0, in1, in2, in3, in4, in5, in6, in7,
    output in8, in9, in10, in11, in12, in13, in14, in15,
    input  done, valid, out0, out1
  );

  modport slave (
    input  run, delay0,
    input  in0, in1, in2, in3, in4, in5, in6, in7,
    input  in8, in9, in10, in11, in12, in13, in14, in15,
    output done, valid, out0, out1
  );
endinterface

// File: rtl/xunit_msched.sv
// rtl/xunit_msched.sv - SHA-256 message schedule generator streaming W[t] and K[t]
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, wins over run
//   bus  xunit_msched_if.slave: run/delay0/in0..in15 in, done/valid/out0/out1 out
// A run pulse optionally waits delay0 cycles, loads the 16-word block into a
// sliding window, then streams 64 (W[t], K[t]) pairs, one per cycle.
module xunit_msched #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  xunit_msched_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_LOAD   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]        state_q,  state_d;
  logic [7:0]        dcnt_q,   dcnt_d;
  logic [5:0]        t_q,      t_d;
  logic [DATA_W-1:0] win_q [16];
  logic [DATA_W-1:0] win_d [16];
  // Last streamed pair, shown on out0/out1 whenever the block is not streaming.
  logic [DATA_W-1:0] last_w_q, last_w_d;
  logic [DATA_W-1:0] last_k_q, last_k_d;
  logic [DATA_W-1:0] w_next;
  logic              streaming;

  assign streaming = (state_q == S_STREAM);
  // window[0]=W[t], [1]=W[t+1], [9]=W[t+9], [14]=W[t+14]
  assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    t_d      = t_q;
    win_d    = win_q;
    last_w_d = last_w_q;
    last_k_d = last_k_q;

    // The current stream cycle is still delivered even if run aborts it,
    // so the held pair is updated independently of the run override.
    if (streaming) begin
      last_w_d = win_q[0];
      last_k_d = K_ROM[t_q];
    end

    if (bus.run) begin
      dcnt_d  = bus.delay0;
      state_d = (bus.delay0 != 8'd0) ? S_DELAY : S_LOAD;
    end else begin
      case (state_q)
        S_DELAY: begin
          dcnt_d = dcnt_q - 8'd1;
          if (dcnt_q <= 8'd1) state_d = S_LOAD;
        end
        S_LOAD: begin
          win_d[0]  = bus.in0;  win_d[1]  = bus.in1;
          win_d[2]  = bus.in2;  win_d[3]  = bus.in3;
          win_d[4]  = bus.in4;  win_d[5]  = bus.in5;
          win_d[6]  = bus.in6;  win_d[7]  = bus.in7;
          win_d[8]  = bus.in8;  win_d[9]  = bus.in9;
          win_d[10] = bus.in10; win_d[11] = bus.in11;
          win_d[12] = bus.in12; win_d[13] = bus.in13;
          win_d[14] = bus.in14; win_d[15] = bus.in15;
          t_d       = 6'd0;
          state_d   = S_STREAM;
        end
        S_STREAM: begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_next;
          t_d       = t_q + 6'd1;
          if (t_q == 6'd63) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dcnt_q   <= '0;
      t_q      <= '0;
      last_w_q <= '0;
      last_k_q <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      t_q      <= t_d;
      last_w_q <= last_w_d;
      last_k_q <= last_k_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign bus.done  = (state_q == S_IDLE);
  assign bus.valid = streaming;
  assign bus.out0  = streaming ? win_q[0]    : last_w_q;
  assign bus.out1  = streaming ? K_ROM[t_q]  : last_k_q;

endmodule

// File: tb/tb_xunit_msched.sv
// tb/tb_xunit_msched.sv - self-checking bench for xunit_msched
module tb_xunit_msched;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  xunit_msched_if #(.DATA_W(32)) bus();

  xunit_msched #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    string       name;
    logic [31:0] in0;
    logic [31:0] in15;
    logic [7:0]  dly;
    logic [31:0] e_w16;
    logic [31:0] e_w17;
  } vec_t;

  logic [31:0] blk    [16];
  logic [31:0] mw     [64];
  logic [31:0] cap_w  [64];
  logic [31:0] cap_k  [64];
  int first_c, last_c, nvalid, done_hi_c;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void model();
    for (int i = 0; i < 16; i++) mw[i] = blk[i];
    for (int i = 16; i < 64; i++)
      mw[i] = (rr(mw[i-2], 17) ^ rr(mw[i-2], 19) ^ (mw[i-2] >> 10)) + mw[i-7]
            + (rr(mw[i-15], 7) ^ rr(mw[i-15], 18) ^ (mw[i-15] >> 3)) + mw[i-16];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_words(input bit rnd);
    bus.in0  = rnd ? $urandom : blk[0];   bus.in1  = rnd ? $urandom : blk[1];
    bus.in2  = rnd ? $urandom : blk[2];   bus.in3  = rnd ? $urandom : blk[3];
    bus.in4  = rnd ? $urandom : blk[4];   bus.in5  = rnd ? $urandom : blk[5];
    bus.in6  = rnd ? $urandom : blk[6];   bus.in7  = rnd ? $urandom : blk[7];
    bus.in8  = rnd ? $urandom : blk[8];   bus.in9  = rnd ? $urandom : blk[9];
    bus.in10 = rnd ? $urandom : blk[10];  bus.in11 = rnd ? $urandom : blk[11];
    bus.in12 = rnd ? $urandom : blk[12];  bus.in13 = rnd ? $urandom : blk[13];
    bus.in14 = rnd ? $urandom : blk[14];  bus.in15 = rnd ? $urandom : blk[15];
  endtask

  // Cycle 0 carries the run pulse; returns #1 into cycle 1.
  task automatic start_run(input logic [7:0] dly);
    @(posedge clk); #1;
    drive_words(0);
    bus.run = 1'b1; bus.delay0 = dly;
    @(posedge clk); #1;
    bus.run = 1'b0; bus.delay0 = 8'($urandom);
  endtask

  task automatic run_block(input logic [7:0] dly, input bit scramble);
    int c;
    first_c = -1; last_c = -1; nvalid = 0; done_hi_c = -1;
    start_run(dly);
    c = 1;
    while (done_hi_c < 0 && c < 400) begin
      @(negedge clk);
      if (bus.valid) begin
        if (nvalid < 64) begin cap_w[nvalid] = bus.out0; cap_k[nvalid] = bus.out1; end
        if (first_c < 0) first_c = c;
        last_c = c;
        nvalid++;
      end
      if (bus.done) done_hi_c = c;
      @(posedge clk); #1;
      if (scramble && nvalid > 0) drive_words(1);
      c++;
    end
  endtask

  function automatic int count_bad();
    int bad = 0;
    for (int i = 0; i < 64; i++)
      if (cap_w[i] !== mw[i] || cap_k[i] !== KT[i]) bad++;
    return bad;
  endfunction

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380; blk[15] = 32'h00000018;
  endtask

  vec_t vecs [5];

  initial begin
    int k, guard;
    vecs[0] = '{"abc_d0",   32'h61626380, 32'h00000018, 8'd0,   32'h61626380, 32'h000f0000};
    vecs[1] = '{"abc_d5",   32'h61626380, 32'h00000018, 8'd5,   32'h61626380, 32'h000f0000};
    vecs[2] = '{"zero_d0",  32'h00000000, 32'h00000000, 8'd0,   32'h00000000, 32'h00000000};
    vecs[3] = '{"one_d1",   32'h00000001, 32'h00000000, 8'd1,   32'h00000001, 32'h00000000};
    vecs[4] = '{"w15_d255", 32'h00000000, 32'h00000001, 8'd255, 32'h00000000, 32'h0000a000};

    rst = 1'b1; bus.run = 1'b0; bus.delay0 = 8'd0;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    drive_words(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done",  32'(bus.done),  32'd1);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_out0",  bus.out0, 32'h0);
    check("rst_out1",  bus.out1, 32'h0);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = vecs[v].in0; blk[15] = vecs[v].in15;
      model();
      run_block(vecs[v].dly, 1'b0);
      check({vecs[v].name, "_first"},  32'(first_c),   32'(vecs[v].dly) + 32'd2);
      check({vecs[v].name, "_last"},   32'(last_c),    32'(vecs[v].dly) + 32'd65);
      check({vecs[v].name, "_donehi"}, 32'(done_hi_c), 32'(vecs[v].dly) + 32'd66);
      check({vecs[v].name, "_nvalid"}, 32'(nvalid),    32'd64);
      check({vecs[v].name, "_w0"},  cap_w[0],  vecs[v].in0);
      check({vecs[v].name, "_w15"}, cap_w[15], vecs[v].in15);
      check({vecs[v].name, "_w16"}, cap_w[16], vecs[v].e_w16);
      check({vecs[v].name, "_w17"}, cap_w[17], vecs[v].e_w17);
      check({vecs[v].name, "_k0"},  cap_k[0],  32'h428a2f98);
      check({vecs[v].name, "_k63"}, cap_k[63], 32'hc67178f2);
      check({vecs[v].name, "_allbad"}, 32'(count_bad()), 32'd0);
      @(negedge clk);
      check({vecs[v].name, "_hold_w"}, bus.out0, mw[63]);
      check({vecs[v].name, "_hold_k"}, bus.out1, 32'hc67178f2);
      check({vecs[v].name, "_idle_v"}, 32'(bus.valid), 32'd0);
    end

    // Abort by run at t=30 and restart with delay0=0.
    set_abc(); model();
    start_run(8'd0);
    k = 0; guard = 0;
    while (k < 30 && guard < 100) begin
      @(negedge clk); if (bus.valid) k++;
      @(posedge clk); #1; guard++;
    end
    check("abort_reach", 32'(k), 32'd30);
    bus.run = 1'b1; bus.delay0 = 8'd0;
    @(negedge clk);
    check("abort_t30_w", bus.out0, mw[30]);
    check("abort_t30_k", bus.out1, KT[30]);
    @(posedge clk); #1 bus.run = 1'b0;
    @(negedge clk);
    check("abort_load_v", 32'(bus.valid), 32'd0);
    check("abort_load_d", 32'(bus.done),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_rs_v",  32'(bus.valid), 32'd1);
    check("abort_rs_w0", bus.out0, mw[0]);
    check("abort_rs_k0", bus.out1, KT[0]);
    k = 0; guard = 0;
    while (!bus.done && guard < 200) begin
      if (bus.valid) k++;
      @(posedge clk); #1; @(negedge clk); guard++;
    end
    check("abort_rs_cnt", 32'(k), 32'd64);

    // Reset mid-stream at t=10.
    start_run(8'd0);
    k = 0; guard = 0;
    while (k < 10 && guard < 100) begin
      @(negedge clk); if (bus.valid) k++;
      @(posedge clk); #1; guard++;
    end
    rst = 1'b1; bus.run = 1'b1; bus.delay0 = 8'd0;
    @(negedge clk);
    check("rstmid_t10_w", bus.out0, mw[10]);
    @(posedge clk); #1 rst = 1'b0; bus.run = 1'b0;
    @(negedge clk);
    check("rstmid_done",  32'(bus.done),  32'd1);
    check("rstmid_valid", 32'(bus.valid), 32'd0);
    check("rstmid_out0",  bus.out0, 32'h0);
    check("rstmid_out1",  bus.out1, 32'h0);
    run_block(8'd2, 1'b0);
    check("post_rst_first", 32'(first_c), 32'd4);
    check("post_rst_all",   32'(count_bad()), 32'd0);

    // Random blocks, inputs scrambled while streaming.
    for (int r = 0; r < 1000; r++) begin
      logic [7:0] d;
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      d = 8'($urandom_range(0, 2));
      model();
      run_block(d, 1'b1);
      check($sformatf("rand%0d", r), 32'(count_bad()) | (32'(nvalid) ^ 32'd64), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xunit_msched.md
XUNIT_MSCHED -- requirements
Module: xunit_msched

Interface
REQ-001 Parameter DATA_W, default 32: data word width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  one-cycle start pulse for one 64-word schedule.
REQ-005 done  output  1  high when idle; low from the cycle after run until the schedule completes.
REQ-006 in0 .. in15  input  DATA_W each  message block words M[0]..M[15], big-endian word order, sampled in the LOAD cycle only.
REQ-007 out0  output  DATA_W  schedule word W[t]; feeds the round unit's w input.
REQ-008 out1  output  DATA_W  round constant K[t]; feeds the round unit's k input.
REQ-009 valid  output  1  high exactly during the 64 STREAM cycles.
REQ-010 delay0  input  8  configured start delay in cycles, sampled on run.

Function
REQ-011 The block SHALL implement states IDLE, DELAY, LOAD and STREAM.
REQ-012 run SHALL have priority in every state: it captures delay0 into the delay counter and moves to DELAY if delay0 != 0, else to LOAD.
REQ-013 In DELAY the counter SHALL decrement once per cycle; when it reaches 0, the next state SHALL be LOAD, giving delay0 idle cycles.
REQ-014 In LOAD the block SHALL copy in0..in15 into a 16-word window W[0..15], clear t to 0 and go to STREAM.
REQ-015 In STREAM cycle t (0..63), out0 SHALL equal window[0] = W[t], out1 SHALL equal K[t] and valid SHALL be 1.
REQ-016 Each STREAM cycle the window SHALL shift down one word and append W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], computed mod 2^32.
REQ-017 s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10 (FIPS 180-4).
REQ-018 K[0..63] SHALL be the FIPS 180-4 SHA-256 constants held in an internal 64-entry ROM indexed by the 6-bit counter t.
REQ-019 After STREAM cycle t=63 the block SHALL go to IDLE; t SHALL NOT wrap into a 65th valid word.
REQ-020 done SHALL be 1 in IDLE and 0 in DELAY, LOAD and STREAM.
REQ-021 Latency: with run at cycle 0, W[0] SHALL appear at cycle delay0+2, W[63] at cycle delay0+65, and done SHALL be 1 from cycle delay0+66.
REQ-022 In IDLE, out0 and out1 SHALL hold their last values and valid SHALL be 0.
REQ-023 run during DELAY, LOAD or STREAM SHALL abort the current schedule without emitting further valid words and restart per REQ-012.
REQ-024 Inputs in0..in15 SHALL be ignored outside the LOAD cycle.

Reset
REQ-025 rst SHALL take priority over run and return the block to IDLE with window, delay counter and t cleared.
REQ-026 After reset: done=1, valid=0, out0=0, out1=0.
REQ-027 rst asserted mid-STREAM SHALL end the schedule on the next edge with no further valid words.

Verification
REQ-028 "abc" block (in0=0x61626380, in1..in14=0, in15=0x00000018), delay0=0, run at cycle 0 -> valid cycles 2..65; W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000; K[0]=0x428A2F98, K[63]=0xC67178F2; done=1 at cycle 66.
REQ-029 Same block with delay0=5 -> first valid at cycle 7, last valid at cycle 70, done low in cycles 1..70.
REQ-030 All-zero block -> out0=0 on all 64 valid cycles, out1 matches the full K table.
REQ-031 run reissued at STREAM t=30 with delay0=0 -> valid drops next cycle, then LOAD and a fresh 64-word stream starting at W[0].
REQ-032 rst at STREAM t=10 -> next cycle done=1, valid=0, out0=0, out1=0; a later run operates normally.
REQ-033 Random blocks (at least 1000) -> all 64 W words match a software FIPS 180-4 model; in0..in15 changed during STREAM have no effect.
